systolic_array_tile_scheduler: RTL and testbench

//  Top-level sequencer for one output-stationary GEMM run on the systolic array.

---
 rtl/systolic_array_tile_scheduler.sv | 162 ++++++++++++++++
 tb/tb_systolic_array_tile_scheduler.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/systolic_array_tile_scheduler.sv
// Tile sequencer for one output-stationary GEMM run on the systolic array.
// Steps each tile through WARMUP -> STEADY -> DRAIN, advancing the SRAM read
// windows by k_len between tiles, and pulses done after the final drain.
module systolic_array_tile_scheduler #(
    parameter int unsigned NUM_ROW              = 8,
    parameter int unsigned NUM_COL              = 8,
    parameter int unsigned LOG2_SRAM_BANK_DEPTH = 10,
    parameter int unsigned CTRL_WIDTH           = 4,
    parameter int unsigned LOG2_MAX_TILES       = 8
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            i_start,
    input  logic                            i_abort,
    input  logic [LOG2_SRAM_BANK_DEPTH-1:0] i_cfg_k_len,
    input  logic [LOG2_MAX_TILES-1:0]       i_cfg_num_tiles,
    input  logic [LOG2_SRAM_BANK_DEPTH-1:0] i_cfg_top_base,
    input  logic [LOG2_SRAM_BANK_DEPTH-1:0] i_cfg_left_base,
    input  logic [NUM_COL-1:0]              i_sa_datapath_valid_down,
    output logic [CTRL_WIDTH-1:0]           o_ctrl_state,
    output logic [LOG2_SRAM_BANK_DEPTH-1:0] o_top_sram_rd_start_addr,
    output logic [LOG2_SRAM_BANK_DEPTH-1:0] o_top_sram_rd_end_addr,
    output logic [LOG2_SRAM_BANK_DEPTH-1:0] o_left_sram_rd_start_addr,
    output logic [LOG2_SRAM_BANK_DEPTH-1:0] o_left_sram_rd_end_addr,
    output logic [LOG2_MAX_TILES-1:0]       o_tile_idx,
    output logic                            o_busy,
    output logic                            o_done,
    output logic                            o_err
);
    localparam int unsigned AW = LOG2_SRAM_BANK_DEPTH;
    localparam int unsigned CW = LOG2_SRAM_BANK_DEPTH + 1;
    localparam int unsigned TW = LOG2_MAX_TILES;
    // Cycle-counter value on the last mandatory drain cycle
    localparam logic [CW-1:0] DRAIN_LAST = CW'(NUM_ROW + NUM_COL - 1);

    typedef enum logic [CTRL_WIDTH-1:0] {
        StIdle,
        StWarmup,
        StSteady,
        StDrain
    } state_e;

    state_e          state_q;
    logic [CW-1:0]   cnt_q;
    logic [AW-1:0]   k_len_q;
    logic [TW-1:0]   num_tiles_q;
    logic [AW-1:0]   top_start_q, top_end_q, left_start_q, left_end_q;
    logic [TW-1:0]   tile_idx_q;
    logic            busy_q, done_q, err_q;

    logic            phase_last;
    logic            drain_last;
    logic            valid_any;
    logic            last_tile;

    assign phase_last = (cnt_q == ({1'b0, k_len_q} - CW'(1)));
    assign drain_last = (cnt_q >= DRAIN_LAST);
    assign valid_any  = |i_sa_datapath_valid_down;
    assign last_tile  = (tile_idx_q == (num_tiles_q - TW'(1)));

    // Sequencer FSM: state, cycle counter, latched config, address windows and pulses
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= StIdle;
            cnt_q        <= '0;
            k_len_q      <= '0;
            num_tiles_q  <= '0;
            top_start_q  <= '0;
            top_end_q    <= '0;
            left_start_q <= '0;
            left_end_q   <= '0;
            tile_idx_q   <= '0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            err_q        <= 1'b0;
        end else begin
            done_q <= 1'b0;
            err_q  <= 1'b0;
            if (i_abort) begin
                // Abort beats any exit/done; in IDLE it simply swallows a start
                if (state_q != StIdle) begin
                    state_q <= StIdle;
                    busy_q  <= 1'b0;
                    cnt_q   <= '0;
                end
            end else begin
                unique case (state_q)
                    StIdle: begin
                        if (i_start) begin
                            if (i_cfg_k_len == '0 || i_cfg_num_tiles == '0) begin
                                err_q <= 1'b1;
                            end else begin
                                k_len_q      <= i_cfg_k_len;
                                num_tiles_q  <= i_cfg_num_tiles;
                                top_start_q  <= i_cfg_top_base;
                                top_end_q    <= i_cfg_top_base + i_cfg_k_len;
                                left_start_q <= i_cfg_left_base;
                                left_end_q   <= i_cfg_left_base + i_cfg_k_len;
                                tile_idx_q   <= '0;
                                cnt_q        <= '0;
                                busy_q       <= 1'b1;
                                state_q      <= StWarmup;
                            end
                        end
                    end
                    StWarmup: begin
                        if (phase_last) begin
                            state_q <= StSteady;
                            cnt_q   <= '0;
                        end else begin
                            cnt_q <= cnt_q + CW'(1);
                        end
                    end
                    StSteady: begin
                        if (phase_last) begin
                            state_q <= StDrain;
                            cnt_q   <= '0;
                        end else begin
                            cnt_q <= cnt_q + CW'(1);
                        end
                    end
                    StDrain: begin
                        // Counter parks at DRAIN_LAST while the datapath is still emitting
                        if (!drain_last) begin
                            cnt_q <= cnt_q + CW'(1);
                        end else if (!valid_any) begin
                            cnt_q <= '0;
                            if (last_tile) begin
                                state_q <= StIdle;
                                busy_q  <= 1'b0;
                                done_q  <= 1'b1;
                            end else begin
                                tile_idx_q   <= tile_idx_q + TW'(1);
                                top_start_q  <= top_start_q + k_len_q;
                                top_end_q    <= top_end_q + k_len_q;
                                left_start_q <= left_start_q + k_len_q;
                                left_end_q   <= left_end_q + k_len_q;
                                state_q      <= StWarmup;
                            end
                        end
                    end
                    default: begin
                        state_q <= StIdle;
                        busy_q  <= 1'b0;
                        cnt_q   <= '0;
                    end
                endcase
            end
        end
    end

    assign o_ctrl_state              = state_q;
    assign o_top_sram_rd_start_addr  = top_start_q;
    assign o_top_sram_rd_end_addr    = top_end_q;
    assign o_left_sram_rd_start_addr = left_start_q;
    assign o_left_sram_rd_end_addr   = left_end_q;
    assign o_tile_idx                = tile_idx_q;
    assign o_busy                    = busy_q;
    assign o_done                    = done_q;
    assign o_err                     = err_q;

endmodule

// File: tb/tb_systolic_array_tile_scheduler.sv
// Bench for systolic_array_tile_scheduler: directed runs push expected state
// segments into a queue; a monitor closes each non-IDLE segment and compares it.
module tb_systolic_array_tile_scheduler;
    localparam int AW = 10;
    localparam int TW = 8;
    localparam int NC = 8;

    logic          clk = 1'b0;
    logic          rst;
    logic          i_start;
    logic          i_abort;
    logic [AW-1:0] i_cfg_k_len;
    logic [TW-1:0] i_cfg_num_tiles;
    logic [AW-1:0] i_cfg_top_base;
    logic [AW-1:0] i_cfg_left_base;
    logic [NC-1:0] valid_down;
    logic [3:0]    o_ctrl_state;
    logic [AW-1:0] o_top_s, o_top_e, o_left_s, o_left_e;
    logic [TW-1:0] o_tile_idx;
    logic          o_busy, o_done, o_err;

    systolic_array_tile_scheduler dut (
        .clk                      (clk),
        .rst                      (rst),
        .i_start                  (i_start),
        .i_abort                  (i_abort),
        .i_cfg_k_len              (i_cfg_k_len),
        .i_cfg_num_tiles          (i_cfg_num_tiles),
        .i_cfg_top_base           (i_cfg_top_base),
        .i_cfg_left_base          (i_cfg_left_base),
        .i_sa_datapath_valid_down (valid_down),
        .o_ctrl_state             (o_ctrl_state),
        .o_top_sram_rd_start_addr (o_top_s),
        .o_top_sram_rd_end_addr   (o_top_e),
        .o_left_sram_rd_start_addr(o_left_s),
        .o_left_sram_rd_end_addr  (o_left_e),
        .o_tile_idx               (o_tile_idx),
        .o_busy                   (o_busy),
        .o_done                   (o_done),
        .o_err                    (o_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0]    st;
        int            len;
        logic [AW-1:0] ts, te, ls, le;
        logic [TW-1:0] tile;
        logic          done_after;
    } seg_t;

    seg_t exp_q[$];
    int   n_checks  = 0;
    int   n_pass    = 0;
    int   exp_done  = 0;
    int   exp_err   = 0;
    int   done_seen = 0;
    int   err_seen  = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act === req) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
    endtask

    // Expected WARMUP/STEADY/DRAIN segments for a complete run
    task automatic push_run(input logic [AW-1:0] k, input int tiles, input logic [AW-1:0] tb,
                            input logic [AW-1:0] lb, input int drain_len);
        logic [AW-1:0] ts;
        logic [AW-1:0] ls;
        ts = tb;
        ls = lb;
        for (int t = 0; t < tiles; t++) begin
            seg_t s;
            s.ts = ts; s.te = ts + k; s.ls = ls; s.le = ls + k;
            s.tile = TW'(t);
            s.done_after = 1'b0;
            s.st = 4'd1; s.len = int'(k); exp_q.push_back(s);
            s.st = 4'd2; exp_q.push_back(s);
            s.st = 4'd3; s.len = drain_len; s.done_after = (t == tiles - 1);
            exp_q.push_back(s);
            ts = ts + k;
            ls = ls + k;
        end
        exp_done++;
    endtask

    task automatic do_start(input logic [AW-1:0] k, input logic [TW-1:0] tiles,
                            input logic [AW-1:0] tb, input logic [AW-1:0] lb);
        @(negedge clk);
        i_cfg_k_len = k; i_cfg_num_tiles = tiles; i_cfg_top_base = tb; i_cfg_left_base = lb;
        i_start = 1'b1;
        @(negedge clk);
        i_start = 1'b0;
        i_cfg_k_len = '0; i_cfg_num_tiles = '0; i_cfg_top_base = '0; i_cfg_left_base = '0;
    endtask

    task automatic wait_state(input logic [3:0] s, input int budget);
        int n;
        n = 0;
        while (o_ctrl_state !== s && n < budget) begin
            @(negedge clk);
            n++;
        end
        if (o_ctrl_state !== s) check("wait_state_timeout", o_ctrl_state, s);
    endtask

    // Monitor: track segments of constant state and score each finished busy segment
    initial begin
        logic [3:0]    cur_st;
        int            seg_len;
        logic [AW-1:0] c_ts, c_te, c_ls, c_le;
        logic [TW-1:0] c_tile;
        logic          c_busy;
        seg_t          e;
        cur_st = 4'd0; seg_len = 0;
        c_ts = '0; c_te = '0; c_ls = '0; c_le = '0; c_tile = '0; c_busy = 1'b0;
        forever begin
            @(negedge clk);
            if (rst) begin
                cur_st = 4'd0;
                seg_len = 0;
                continue;
            end
            if (o_err === 1'b1) err_seen++;
            if (o_done === 1'b1) done_seen++;
            if (o_ctrl_state !== cur_st) begin
                if (cur_st != 4'd0) begin
                    if (exp_q.size() == 0) begin
                        check("unexpected_segment", {28'd0, cur_st}, 32'hFFFF_FFFF);
                    end else begin
                        e = exp_q.pop_front();
                        check("seg_state", {28'd0, cur_st}, {28'd0, e.st});
                        if (e.len >= 0) check("seg_len", seg_len, e.len);
                        check("seg_top_start", {22'd0, c_ts}, {22'd0, e.ts});
                        check("seg_top_end", {22'd0, c_te}, {22'd0, e.te});
                        check("seg_left_start", {22'd0, c_ls}, {22'd0, e.ls});
                        check("seg_left_end", {22'd0, c_le}, {22'd0, e.le});
                        check("seg_tile_idx", {24'd0, c_tile}, {24'd0, e.tile});
                        check("seg_busy", {31'd0, c_busy}, 32'd1);
                        check("done_at_exit", {31'd0, o_done}, {31'd0, e.done_after});
                    end
                end
                if (o_ctrl_state == 4'd0) check("busy_at_idle", {31'd0, o_busy}, 32'd0);
                cur_st = o_ctrl_state;
                seg_len = 1;
                c_ts = o_top_s; c_te = o_top_e; c_ls = o_left_s; c_le = o_left_e;
                c_tile = o_tile_idx; c_busy = o_busy;
            end else begin
                seg_len++;
            end
        end
    end

    // Global time limit so the bench can never hang
    initial begin
        #500000;
        $display("FAIL global_timeout: simulation did not finish, got timeout, expected finish");
        $fatal(1, "timeout");
    end

    // Directed stimulus
    initial begin
        seg_t a;
        rst = 1'b1; i_start = 1'b0; i_abort = 1'b0; valid_down = '0;
        i_cfg_k_len = '0; i_cfg_num_tiles = '0; i_cfg_top_base = '0; i_cfg_left_base = '0;
        repeat (3) @(negedge clk);
        check("rst_state", {28'd0, o_ctrl_state}, 32'd0);
        check("rst_top_start", {22'd0, o_top_s}, 32'd0);
        check("rst_top_end", {22'd0, o_top_e}, 32'd0);
        check("rst_left_start", {22'd0, o_left_s}, 32'd0);
        check("rst_left_end", {22'd0, o_left_e}, 32'd0);
        check("rst_tile_idx", {24'd0, o_tile_idx}, 32'd0);
        check("rst_flags", {29'd0, o_busy, o_done, o_err}, 32'd0);
        rst = 1'b0;

        // Single tile, no drain extension
        push_run(10'd4, 1, 10'h010, 10'h020, 16);
        do_start(10'd4, 8'd1, 10'h010, 10'h020);
        wait_state(4'd0, 200);
        check("t1_hold_top_start", {22'd0, o_top_s}, 32'h010);
        check("t1_hold_top_end", {22'd0, o_top_e}, 32'h014);
        check("t1_hold_left_start", {22'd0, o_left_s}, 32'h020);
        check("t1_hold_left_end", {22'd0, o_left_e}, 32'h024);

        // Three back-to-back tiles
        push_run(10'd2, 3, 10'h010, 10'h100, 16);
        do_start(10'd2, 8'd3, 10'h010, 10'h100);
        wait_state(4'd0, 300);
        check("t2_last_top_start", {22'd0, o_top_s}, 32'h014);
        check("t2_last_left_start", {22'd0, o_left_s}, 32'h104);
        check("t2_last_tile_idx", {24'd0, o_tile_idx}, 32'd2);

        // Address wrap at the top of the bank
        push_run(10'd4, 2, 10'h3FE, 10'h000, 16);
        do_start(10'd4, 8'd2, 10'h3FE, 10'h000);
        wait_state(4'd0, 300);
        check("t3_wrap_top_start", {22'd0, o_top_s}, 32'h002);
        check("t3_wrap_top_end", {22'd0, o_top_e}, 32'h006);

        // Drain extended by valid_down: 21 drain cycles
        push_run(10'd4, 1, 10'h040, 10'h080, 21);
        do_start(10'd4, 8'd1, 10'h040, 10'h080);
        wait_state(4'd3, 100);
        valid_down = 8'h01;
        repeat (20) @(negedge clk);
        valid_down = '0;
        wait_state(4'd0, 100);

        // Illegal configs: err pulse, stays idle
        do_start(10'd0, 8'd1, 10'h000, 10'h000);
        exp_err++;
        check("err_k0_pulse", {31'd0, o_err}, 32'd1);
        check("err_k0_busy", {31'd0, o_busy}, 32'd0);
        do_start(10'd4, 8'd0, 10'h000, 10'h000);
        exp_err++;
        check("err_n0_pulse", {31'd0, o_err}, 32'd1);
        @(negedge clk);
        check("err_n0_state", {28'd0, o_ctrl_state}, 32'd0);

        // Start while busy is ignored
        push_run(10'd2, 1, 10'h000, 10'h000, 16);
        do_start(10'd2, 8'd1, 10'h000, 10'h000);
        wait_state(4'd2, 50);
        do_start(10'd0, 8'd5, 10'h123, 10'h321);
        wait_state(4'd0, 100);

        // Abort in IDLE drops a simultaneous start
        @(negedge clk);
        i_cfg_k_len = 10'd4; i_cfg_num_tiles = 8'd1;
        i_start = 1'b1; i_abort = 1'b1;
        @(negedge clk);
        i_start = 1'b0; i_abort = 1'b0;
        check("abort_idle_busy", {31'd0, o_busy}, 32'd0);
        @(negedge clk);
        check("abort_idle_state", {28'd0, o_ctrl_state}, 32'd0);

        // Abort in cycle 2 of STEADY
        a.ts = 10'h100; a.te = 10'h103; a.ls = 10'h200; a.le = 10'h203;
        a.tile = '0; a.done_after = 1'b0;
        a.st = 4'd1; a.len = 3; exp_q.push_back(a);
        a.st = 4'd2; a.len = 2; exp_q.push_back(a);
        do_start(10'd3, 8'd3, 10'h100, 10'h200);
        wait_state(4'd2, 50);
        @(negedge clk);
        i_abort = 1'b1;
        @(negedge clk);
        i_abort = 1'b0;
        check("abort_state", {28'd0, o_ctrl_state}, 32'd0);
        check("abort_busy", {31'd0, o_busy}, 32'd0);
        check("abort_done", {31'd0, o_done}, 32'd0);

        // Normal run after abort
        push_run(10'd1, 1, 10'h005, 10'h006, 16);
        do_start(10'd1, 8'd1, 10'h005, 10'h006);
        wait_state(4'd0, 100);
        check("post_abort_top_start", {22'd0, o_top_s}, 32'h005);
        check("post_abort_tile_idx", {24'd0, o_tile_idx}, 32'd0);

        repeat (5) @(negedge clk);
        check("queue_drained", exp_q.size(), 32'd0);
        check("done_count", done_seen, exp_done);
        check("err_count", err_seen, exp_err);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
